// File: rtl/faerie_pkg.sv
`default_nettype none
// ============================================================================
// Module      : faerie_pkg
// Description : Shared constants and types for the Faerie CPU address unit:
//               flag bit positions, branch-mode encodings, reset vector
//               addresses and the start-up state enumeration.
//               FAERIE_RESET_VECTOR_EN selects the vector fetch start-up
//               (VEC_LO/VEC_HI/VEC_DONE) instead of the single RST1 state.
// Revision    : 1.0 - initial release
// ============================================================================
package faerie_pkg;

    // Bit positions inside the {V,N,Z,C} flags nibble
    localparam int c_FLAG_C = 0;
    localparam int c_FLAG_Z = 1;
    localparam int c_FLAG_N = 2;
    localparam int c_FLAG_V = 3;

    // Branch condition selector mode[2:0]; mode[c_MODE_INV] inverts it
    localparam logic [2:0] c_BR_ALWAYS = 3'd0;
    localparam logic [2:0] c_BR_C      = 3'd1;
    localparam logic [2:0] c_BR_Z      = 3'd2;
    localparam logic [2:0] c_BR_N      = 3'd3;
    localparam logic [2:0] c_BR_V      = 3'd4;
    localparam logic [2:0] c_BR_HI     = 3'd5;   // C & !Z
    localparam logic [2:0] c_BR_LT     = 3'd6;   // N ^ V
    localparam logic [2:0] c_BR_LE     = 3'd7;   // (N ^ V) | Z
    localparam int         c_MODE_INV  = 3;

    // Reset vector location (little-endian pointer)
    localparam logic [15:0] c_VEC_LO_ADDR = 16'hFFFC;
    localparam logic [15:0] c_VEC_HI_ADDR = 16'hFFFD;

    // Start-up sequencer states; RUN is the only state with cu_rst low
    typedef enum logic [2:0] {
        ST_RST1     = 3'd0,
        ST_VEC_LO   = 3'd1,
        ST_VEC_HI   = 3'd2,
        ST_VEC_DONE = 3'd3,
        ST_RUN      = 3'd4
    } startup_state_t;

`ifdef FAERIE_RESET_VECTOR_EN
    localparam startup_state_t c_ST_FIRST = ST_VEC_LO;
`else
    localparam startup_state_t c_ST_FIRST = ST_RST1;
`endif

endpackage : faerie_pkg
`default_nettype wire

// File: rtl/faerie_branch_cond.sv
`default_nettype none
// ============================================================================
// Module      : faerie_branch_cond
// Description : Combinational branch condition decoder. Evaluates mode[2:0]
//               against the {V,N,Z,C} flags; mode[3] inverts the result.
// Revision    : 1.0 - initial release
// ============================================================================
module faerie_branch_cond
    import faerie_pkg::*;
(
    input  logic [3:0] mode,
    input  logic [3:0] flags,
    output logic       taken
);

    logic w_c;
    logic w_z;
    logic w_n;
    logic w_v;
    logic w_cond;

    assign w_c = flags[c_FLAG_C];
    assign w_z = flags[c_FLAG_Z];
    assign w_n = flags[c_FLAG_N];
    assign w_v = flags[c_FLAG_V];

    // Select the raw condition, then apply the optional inversion
    always_comb begin
        w_cond = 1'b0;
        case (mode[2:0])
            c_BR_ALWAYS: w_cond = 1'b1;
            c_BR_C:      w_cond = w_c;
            c_BR_Z:      w_cond = w_z;
            c_BR_N:      w_cond = w_n;
            c_BR_V:      w_cond = w_v;
            c_BR_HI:     w_cond = w_c & ~w_z;
            c_BR_LT:     w_cond = w_n ^ w_v;
            c_BR_LE:     w_cond = (w_n ^ w_v) | w_z;
            default:     w_cond = 1'b0;
        endcase
        taken = w_cond ^ mode[c_MODE_INV];
    end

endmodule : faerie_branch_cond
`default_nettype wire

// File: rtl/faerie_addr_unit.sv
`default_nettype none
// ============================================================================
// Module      : faerie_addr_unit
// Description : Faerie CPU address unit. Holds PC, the AH:AL operand pointer
//               and the flags register, multiplexes the memory address, and
//               sequences start-up while holding the control unit in reset.
//               Define FAERIE_RESET_VECTOR_EN to fetch the start PC from the
//               vector at 16'hFFFC/16'hFFFD; otherwise PC starts at RESET_PC.
// Revision    : 1.0 - initial release
// ============================================================================
module faerie_addr_unit
    import faerie_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rdata,
    input  logic [3:0]  mode,
    input  logic        re,
    input  logic        pc_addr,
    input  logic        set_al,
    input  logic        set_ah,
    input  logic        zp_addr,
    input  logic        inc_al,
    input  logic        branch,
    input  logic        set_fr,
    input  logic [3:0]  alu_flags,
    output logic [15:0] addr,
    output logic        vec_re,
    output logic        cu_rst,
    output logic [3:0]  flags,
    output logic [15:0] pc
);

    // PC is loaded from the vector when it is enabled, so it resets to zero
`ifdef FAERIE_RESET_VECTOR_EN
    localparam logic [15:0] c_PC_INIT = 16'h0000;
`else
    localparam logic [15:0] c_PC_INIT = RESET_PC;
`endif

    startup_state_t r_state;
    startup_state_t w_state_next;
    logic [15:0]    w_startup_addr;
    logic           w_run;
    logic           w_taken;
    logic [15:0]    r_pc;
    logic [7:0]     r_al;
    logic [7:0]     r_ah;
    logic [3:0]     r_flags;

    assign w_run = (r_state == ST_RUN);

    faerie_branch_cond u_branch_cond (
        .mode  (mode),
        .flags (r_flags),
        .taken (w_taken)
    );

    // Start-up state register; reset always restarts the whole sequence
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_FIRST;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Start-up next state, control-unit reset, vector read enable and address
    always_comb begin
        w_state_next   = r_state;
        w_startup_addr = c_PC_INIT;
        cu_rst         = 1'b1;
        vec_re         = 1'b0;
        case (r_state)
`ifdef FAERIE_RESET_VECTOR_EN
            ST_VEC_LO: begin
                w_state_next   = ST_VEC_HI;
                w_startup_addr = c_VEC_LO_ADDR;
                vec_re         = 1'b1;
            end
            ST_VEC_HI: begin
                w_state_next   = ST_VEC_DONE;
                w_startup_addr = c_VEC_HI_ADDR;
                vec_re         = 1'b1;
            end
            ST_VEC_DONE: begin
                // High byte arrives this cycle; keep the bus on the vector
                w_state_next   = ST_RUN;
                w_startup_addr = c_VEC_HI_ADDR;
            end
`else
            ST_RST1: begin
                w_state_next   = ST_RUN;
                w_startup_addr = RESET_PC;
            end
`endif
            ST_RUN: begin
                cu_rst = 1'b0;
            end
            default: begin
                w_state_next = c_ST_FIRST;
            end
        endcase
    end

    // Memory address: start-up address, else PC, zero page or full pointer
    assign addr = !w_run  ? w_startup_addr :
                  pc_addr ? r_pc :
                  zp_addr ? {8'h00, r_al} :
                            {r_ah, r_al};

    // PC, pointer and flags; strobes only act while the control unit runs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= c_PC_INIT;
            r_al    <= 8'h00;
            r_ah    <= 8'h00;
            r_flags <= 4'h0;
        end else if (w_run) begin
            // A taken branch wins over the sequential fetch increment
            if (branch && w_taken) begin
                r_pc <= {r_ah, r_al};
            end else if (re && pc_addr) begin
                r_pc <= r_pc + 16'd1;
            end
            // A load of AL wins over its increment; AH is never carried into
            if (set_al) begin
                r_al <= rdata;
            end else if (inc_al) begin
                r_al <= r_al + 8'd1;
            end
            if (set_ah) begin
                r_ah <= rdata;
            end
            if (set_fr) begin
                r_flags <= alu_flags;
            end
        end
`ifdef FAERIE_RESET_VECTOR_EN
        else if (r_state == ST_VEC_HI) begin
            // Data for the 16'hFFFC read returns one cycle after VEC_LO
            r_pc[7:0] <= rdata;
        end else if (r_state == ST_VEC_DONE) begin
            r_pc[15:8] <= rdata;
        end
`endif
    end

    assign pc    = r_pc;
    assign flags = r_flags;

endmodule : faerie_addr_unit
`default_nettype wire

// File: tb/tb_faerie_addr_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_faerie_addr_unit
// Description : Self-checking bench for faerie_addr_unit. Directed start-up,
//               pointer, branch, wrap and reset scenarios followed by random
//               traffic, all compared against a cycle-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_faerie_addr_unit;

    localparam logic [15:0] c_RESET_PC = 16'hC000;
`ifdef FAERIE_RESET_VECTOR_EN
    localparam bit          c_VEC       = 1'b1;
    localparam logic [15:0] c_PC_AT_RST = 16'h0000;
    localparam int          c_START_LEN = 3;
`else
    localparam bit          c_VEC       = 1'b0;
    localparam logic [15:0] c_PC_AT_RST = c_RESET_PC;
    localparam int          c_START_LEN = 1;
`endif

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  rdata;
    logic [3:0]  mode;
    logic        re, pc_addr, set_al, set_ah, zp_addr, inc_al, branch, set_fr;
    logic [3:0]  alu_flags;
    logic [15:0] addr;
    logic        vec_re;
    logic        cu_rst;
    logic [3:0]  flags;
    logic [15:0] pc;

    // Reference model state
    int          m_phase;   // cycles of start-up completed; == c_START_LEN in RUN
    logic [15:0] m_pc;
    logic [7:0]  m_al;
    logic [7:0]  m_ah;
    logic [3:0]  m_flags;

    int total = 0;
    int bad   = 0;

    faerie_addr_unit #(.RESET_PC(c_RESET_PC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rdata     (rdata),
        .mode      (mode),
        .re        (re),
        .pc_addr   (pc_addr),
        .set_al    (set_al),
        .set_ah    (set_ah),
        .zp_addr   (zp_addr),
        .inc_al    (inc_al),
        .branch    (branch),
        .set_fr    (set_fr),
        .alu_flags (alu_flags),
        .addr      (addr),
        .vec_re    (vec_re),
        .cu_rst    (cu_rst),
        .flags     (flags),
        .pc        (pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Branch rule written straight from the flag definitions
    function automatic bit ref_taken(input logic [3:0] md, input logic [3:0] f);
        bit c, z, n, v, r;
        c = f[0]; z = f[1]; n = f[2]; v = f[3];
        case (md[2:0])
            3'd0: r = 1'b1;
            3'd1: r = c;
            3'd2: r = z;
            3'd3: r = n;
            3'd4: r = v;
            3'd5: r = c && !z;
            3'd6: r = (n != v);
            default: r = (n != v) || z;
        endcase
        return md[3] ? !r : r;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_pc    = c_PC_AT_RST;
        m_al    = 8'h00;
        m_ah    = 8'h00;
        m_flags = 4'h0;
    endtask

    task automatic idle();
        re = 0; pc_addr = 0; set_al = 0; set_ah = 0; zp_addr = 0;
        inc_al = 0; branch = 0; set_fr = 0; mode = 4'h0;
        alu_flags = 4'h0; rdata = 8'h00;
    endtask

    // One clock: check address-side outputs before the edge, advance the
    // model with the applied inputs, then check registers after the edge.
    task automatic step();
        logic [15:0] next_pc;
        bool_t_dummy: begin end
        @(negedge clk);
        check("cu_rst", 16'(cu_rst), 16'(m_phase < c_START_LEN));
        check("vec_re", 16'(vec_re), 16'(c_VEC && m_phase < 2));
        if (m_phase >= c_START_LEN) begin
            check("addr", addr, pc_addr ? m_pc : zp_addr ? {8'h00, m_al} : {m_ah, m_al});
        end else if (!c_VEC) begin
            check("addr_rst1", addr, c_RESET_PC);
        end else if (m_phase < 2) begin
            check("addr_vec", addr, (m_phase == 0) ? 16'hFFFC : 16'hFFFD);
        end
        if (m_phase < c_START_LEN) begin
            if (c_VEC && m_phase == 1) m_pc[7:0]  = rdata;
            if (c_VEC && m_phase == 2) m_pc[15:8] = rdata;
            m_phase++;
        end else begin
            next_pc = m_pc;
            if (branch && ref_taken(mode, m_flags)) next_pc = {m_ah, m_al};
            else if (re && pc_addr)                 next_pc = 16'((int'(m_pc) + 1) % 65536);
            m_pc = next_pc;
            if (set_al)      m_al = rdata;
            else if (inc_al) m_al = 8'((int'(m_al) + 1) % 256);
            if (set_ah) m_ah = rdata;
            if (set_fr) m_flags = alu_flags;
        end
        @(posedge clk);
        #1;
        check("pc", pc, m_pc);
        check("flags", 16'(flags), 16'(m_flags));
    endtask

    // Assert reset between edges, check it acts at once, release after an edge
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_pc", pc, c_PC_AT_RST);
        check("rst_flags", 16'(flags), 16'h0);
        check("rst_cu_rst", 16'(cu_rst), 16'h1);
        check("rst_addr", addr, c_VEC ? 16'hFFFC : c_RESET_PC);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Walk the start-up sequence with junk strobes that must be ignored
    task automatic run_startup();
        int vr = 0;
        int cr = 0;
        for (int i = 0; i < 8 && m_phase < c_START_LEN; i++) begin
            vr += int'(vec_re);
            cr += int'(cu_rst);
            rdata     = (m_phase == 1) ? 8'h34 : (m_phase == 2) ? 8'h12 : 8'h00;
            set_al    = 1'($urandom);
            set_ah    = 1'($urandom);
            inc_al    = 1'($urandom);
            set_fr    = 1'($urandom);
            alu_flags = 4'($urandom);
            re = 1; pc_addr = 1; branch = 1; mode = 4'h0;
            step();
        end
        idle();
        check("startup_vec_re_cycles", 16'(vr), c_VEC ? 16'd2 : 16'd0);
        check("startup_cu_rst_cycles", 16'(cr), 16'(c_START_LEN));
        check("startup_pc", pc, c_VEC ? 16'h1234 : c_RESET_PC);
        check("run_cu_rst", 16'(cu_rst), 16'h0);
    endtask

    task automatic load_ptr(input logic [7:0] hi, input logic [7:0] lo);
        idle(); set_al = 1; rdata = lo; step();
        idle(); set_ah = 1; rdata = hi; step();
        idle();
    endtask

    initial begin
        idle();
        model_reset();
        do_reset();
        run_startup();

        // Zero-page pointer: AL wraps to 00 while AH loads 80
        idle(); set_al = 1; rdata = 8'hFF; step();
        idle(); set_ah = 1; inc_al = 1; rdata = 8'h80; step();
        idle(); zp_addr = 1; #1;
        check("zp_addr", addr, 16'h0000);
        zp_addr = 0; #1;
        check("abs_addr", addr, 16'h8000);
        step();

        // Branch on Z: taken with mode 2, inverted mode A falls through
        idle(); set_fr = 1; alu_flags = 4'b0010; step();
        load_ptr(8'h40, 8'h00);
        mode = 4'h2; branch = 1; re = 1; pc_addr = 1; step();
        check("br_taken", pc, 16'h4000);
        mode = 4'hA; step();
        check("br_not_taken", pc, 16'h4001);

        // PC wrap from FFFF
        load_ptr(8'hFF, 8'hFF);
        branch = 1; mode = 4'h0; step();
        check("pc_ffff", pc, 16'hFFFF);
        idle(); re = 1; pc_addr = 1; step();
        check("pc_wrap", pc, 16'h0000);
        check("pc_wrap_addr", addr, 16'h0000);

        // Reset in the middle of start-up
        idle();
        do_reset();
        rdata = 8'h77; step();
        do_reset();
        run_startup();

        // Reset during RUN with PC=0123 and live flags/pointer
        idle(); set_fr = 1; alu_flags = 4'hF; step();
        load_ptr(8'h01, 8'h23);
        branch = 1; mode = 4'h0; step();
        check("pc_0123", pc, 16'h0123);
        idle();
        do_reset();
        run_startup();
        idle(); step();
        check("ptr_cleared", addr, 16'h0000);

        // Random traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            rdata     = 8'($urandom);
            mode      = 4'($urandom);
            alu_flags = 4'($urandom);
            re        = 1'($urandom);
            pc_addr   = 1'($urandom);
            zp_addr   = 1'($urandom);
            set_al    = ($urandom_range(0, 3) == 0);
            set_ah    = ($urandom_range(0, 3) == 0);
            inc_al    = ($urandom_range(0, 2) == 0);
            branch    = ($urandom_range(0, 3) == 0);
            set_fr    = ($urandom_range(0, 2) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_faerie_addr_unit
`default_nettype wire
